// File: rtl/bus_cycle_pkg.sv
// Shared types and decode constants for the bus cycle controller.
// FAULT state exists only when BUS_CYCLE_TIMEOUT_EN is defined.
package bus_cycle_pkg;

`ifdef BUS_CYCLE_TIMEOUT_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_WAIT,
    ST_ACK,
    ST_FAULT
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_WAIT,
    ST_ACK
  } state_t;
`endif

  typedef enum logic [2:0] {
    REG_SRAM,
    REG_ROM,
    REG_DUART,
    REG_NONE,
    REG_CPU
  } region_t;

  localparam logic [1:0] AH_SRAM  = 2'b00;
  localparam logic [1:0] AH_NONE  = 2'b01;
  localparam logic [1:0] AH_ROM   = 2'b10;
  localparam logic [1:0] AH_DUART = 2'b11;
  localparam logic [2:0] FC_CPU   = 3'b111;
  localparam int BOOT_CYCLES = 2;

  function automatic region_t decode_region(
    input logic [2:0] fc,
    input logic [1:0] ah,
    input logic       boot
  );
    region_t r;
    r = REG_NONE;
    if (fc == FC_CPU) begin
      r = REG_CPU;
    end else if (!boot) begin
      r = REG_ROM;
    end else begin
      case (ah)
        AH_SRAM:  r = REG_SRAM;
        AH_ROM:   r = REG_ROM;
        AH_DUART: r = REG_DUART;
        AH_NONE:  r = REG_NONE;
        default:  r = REG_NONE;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/bus_cycle_controller_timer.sv
// Wait-state counter and bus-error watchdog for the bus cycle controller.
// Watchdog built only when BUS_CYCLE_TIMEOUT_EN is defined.
module cycle_timer #(
  parameter int TIMEOUT_CYCLES = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  input  logic       wd_start,
  input  logic       wd_run,
  output logic       zero,
  output logic       expire
);

  logic [3:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // zero flags the clock on which a decrement lands the count on 0
  assign zero = (cnt == 4'd1);

`ifdef BUS_CYCLE_TIMEOUT_EN
  logic [7:0] wd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd <= '0;
    end else if (wd_start) begin
      wd <= 8'd1;
    end else if (wd_run) begin
      wd <= wd + 8'd1;
    end else begin
      wd <= '0;
    end
  end

  assign expire = wd_run && ((wd + 8'd1) == TIMEOUT_CYCLES[7:0]);
`else
  logic unused_wd;
  assign unused_wd = wd_start ^ wd_run ^ TIMEOUT_CYCLES[0];
  assign expire = 1'b0;
`endif

endmodule

// File: rtl/bus_cycle_controller.sv
// 68k-style bus cycle controller: region decode, wait states, acknowledge.
// Define BUS_CYCLE_TIMEOUT_EN to build the bus-error watchdog and FAULT state.
module bus_cycle_controller
  import bus_cycle_pkg::*;
#(
  parameter int ROM_WAIT       = 2,
  parameter int SRAM_WAIT      = 0,
  parameter int DUART_WAIT     = 3,
  parameter int TIMEOUT_CYCLES = 128
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       AS_n,
  input  logic       DS_n,
  input  logic       RW,
  input  logic [2:0] FC,
  input  logic [1:0] AH,
  output logic       CS_ROM_n,
  output logic       CS_SRAM_n,
  output logic       CS_DUART_n,
  output logic       DSACK0_n,
  output logic       DSACK1_n,
  output logic       AVEC_n,
  output logic       BERR_n,
  output logic       BUSY
);

  state_t     state, state_nxt;
  region_t    region;
  logic       boot;
  logic [1:0] boot_cnt;
  logic       ds_q;
  logic [3:0] wait_val;
  logic       t_load, t_dec, t_zero, t_expire;
  logic       wd_start, wd_run;
  logic       mapped, ack_entry;
  logic       unused_rw;

  assign unused_rw = RW;

  always_comb begin
    wait_val = 4'd0;
    case (region)
      REG_SRAM:  wait_val = 4'(SRAM_WAIT);
      REG_ROM:   wait_val = 4'(ROM_WAIT);
      REG_DUART: wait_val = 4'(DUART_WAIT);
      default:   wait_val = 4'd0;
    endcase
  end

  assign mapped   = (region != REG_NONE);
  assign wd_start = (state == ST_IDLE) && !AS_n;
  assign wd_run   = (state == ST_DECODE) || (state == ST_WAIT);

  cycle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (CLK),
    .rst     (RST),
    .load    (t_load),
    .load_val(wait_val),
    .dec     (t_dec),
    .wd_start(wd_start),
    .wd_run  (wd_run),
    .zero    (t_zero),
    .expire  (t_expire)
  );

  always_comb begin
    state_nxt = state;
    t_load    = 1'b0;
    t_dec     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!AS_n) state_nxt = ST_DECODE;
      end
      ST_DECODE: begin
        if (AS_n) begin
          state_nxt = ST_IDLE;
        end else begin
          t_load = 1'b1;
          if (!mapped)               state_nxt = ST_WAIT;
          else if (wait_val == 4'd0) state_nxt = ST_ACK;
          else                       state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        t_dec = mapped;
        if (AS_n) begin
          state_nxt = ST_IDLE;
        end else if (mapped && t_zero) begin
          state_nxt = ST_ACK;
`ifdef BUS_CYCLE_TIMEOUT_EN
        end else if (t_expire) begin
          state_nxt = ST_FAULT;
`endif
        end
      end
      ST_ACK: begin
        if (AS_n) state_nxt = ST_IDLE;
      end
`ifdef BUS_CYCLE_TIMEOUT_EN
      ST_FAULT: begin
        if (AS_n) state_nxt = ST_IDLE;
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign ack_entry = (state_nxt == ST_ACK) && (state != ST_ACK);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= ST_IDLE;
      region   <= REG_NONE;
      ds_q     <= 1'b1;
      boot     <= 1'b0;
      boot_cnt <= '0;
    end else begin
      state <= state_nxt;
      ds_q  <= DS_n;
      if (wd_start) region <= decode_region(FC, AH, boot);
      // boot ROM overlay lifts once enough cycles have completed
      if (ack_entry && !boot) begin
        boot_cnt <= boot_cnt + 2'd1;
        if (boot_cnt == 2'(BOOT_CYCLES - 1)) boot <= 1'b1;
      end
    end
  end

  logic sel, ack;
  assign BUSY = (state != ST_IDLE);
  assign sel  = BUSY && !ds_q;
  assign ack  = (state == ST_ACK);

  assign CS_ROM_n   = !(sel && region == REG_ROM);
  assign CS_SRAM_n  = !(sel && region == REG_SRAM);
  assign CS_DUART_n = !(sel && region == REG_DUART);
  assign DSACK0_n   = !(ack && mapped && region != REG_CPU);
  assign DSACK1_n   = 1'b1;
  assign AVEC_n     = !(ack && region == REG_CPU);
`ifdef BUS_CYCLE_TIMEOUT_EN
  assign BERR_n     = !(state == ST_FAULT);
`else
  assign BERR_n     = 1'b1;
`endif

endmodule

// File: tb/tb_bus_cycle_controller.sv
// Directed self-checking bench for bus_cycle_controller.
// Output vector order: ROM SRAM DUART DSACK0 DSACK1 AVEC BERR BUSY.
module tb_bus_cycle_controller;

  logic       CLK = 1'b0;
  logic       RST;
  logic       AS_n, DS_n, RW;
  logic [2:0] FC;
  logic [1:0] AH;
  logic       CS_ROM_n, CS_SRAM_n, CS_DUART_n;
  logic       DSACK0_n, DSACK1_n, AVEC_n, BERR_n, BUSY;
  logic [7:0] outs;

  int total = 0;
  int bad   = 0;

  localparam logic [7:0] IDLE_O  = 8'b111_11_11_0;
  localparam logic [7:0] NOCS_O  = 8'b111_11_11_1;
  localparam logic [7:0] ROM_O   = 8'b011_11_11_1;
  localparam logic [7:0] ROMA_O  = 8'b011_01_11_1;
  localparam logic [7:0] SRAM_O  = 8'b101_11_11_1;
  localparam logic [7:0] SRAMA_O = 8'b101_01_11_1;
  localparam logic [7:0] DUA_O   = 8'b110_11_11_1;
  localparam logic [7:0] DUAA_O  = 8'b110_01_11_1;
  localparam logic [7:0] AVEC_O  = 8'b111_11_01_1;
  localparam logic [7:0] BERR_O  = 8'b111_11_10_1;

  always #5 CLK = ~CLK;

  assign outs = {CS_ROM_n, CS_SRAM_n, CS_DUART_n,
                 DSACK0_n, DSACK1_n, AVEC_n, BERR_n, BUSY};

  bus_cycle_controller dut (
    .CLK       (CLK),
    .RST       (RST),
    .AS_n      (AS_n),
    .DS_n      (DS_n),
    .RW        (RW),
    .FC        (FC),
    .AH        (AH),
    .CS_ROM_n  (CS_ROM_n),
    .CS_SRAM_n (CS_SRAM_n),
    .CS_DUART_n(CS_DUART_n),
    .DSACK0_n  (DSACK0_n),
    .DSACK1_n  (DSACK1_n),
    .AVEC_n    (AVEC_n),
    .BERR_n    (BERR_n),
    .BUSY      (BUSY)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] exp);
    total++;
    assert (outs === exp) else begin
      bad++;
      $error("FAIL %s: got %b want %b", tag, outs, exp);
    end
  endtask

  task automatic start(input logic [2:0] fc, input logic [1:0] ah,
                       input logic ds);
    FC   = fc;
    AH   = ah;
    RW   = 1'b1;
    AS_n = 1'b0;
    DS_n = ds;
  endtask

  task automatic release_bus();
    AS_n = 1'b1;
    DS_n = 1'b1;
  endtask

  task automatic rd(input string tag, input logic [2:0] fc,
                    input logic [1:0] ah, input int w,
                    input logic [7:0] sel_o, input logic [7:0] ack_o);
    start(fc, ah, 1'b0);
    for (int c = 1; c <= w + 1; c++) begin
      tick();
      chk($sformatf("%s.c%0d", tag, c), sel_o);
    end
    tick();
    chk({tag, ".ack"}, ack_o);
    tick();
    chk({tag, ".hold"}, ack_o);
    release_bus();
    tick();
    chk({tag, ".end"}, IDLE_O);
  endtask

  initial begin
    RST  = 1'b1;
    AS_n = 1'b1;
    DS_n = 1'b1;
    RW   = 1'b1;
    FC   = 3'b101;
    AH   = 2'b00;
    tick();
    chk("reset", IDLE_O);
    tick();
    RST = 1'b0;
    tick();
    chk("post_reset", IDLE_O);

    rd("boot1", 3'b101, 2'b00, 2, ROM_O, ROMA_O);
    rd("boot2", 3'b101, 2'b00, 2, ROM_O, ROMA_O);
    rd("sram", 3'b101, 2'b00, 0, SRAM_O, SRAMA_O);
    rd("duart", 3'b101, 2'b11, 3, DUA_O, DUAA_O);
    rd("rom", 3'b110, 2'b10, 2, ROM_O, ROMA_O);
    rd("cpu", 3'b111, 2'b00, 0, NOCS_O, AVEC_O);

    start(3'b101, 2'b01, 1'b0);
`ifdef BUS_CYCLE_TIMEOUT_EN
    repeat (127) tick();
    chk("unmap.c127", NOCS_O);
    tick();
    chk("unmap.c128", BERR_O);
    tick();
    chk("unmap.hold", BERR_O);
`else
    repeat (30) tick();
    chk("unmap.c30", NOCS_O);
`endif
    release_bus();
    tick();
    chk("unmap.end", IDLE_O);

    start(3'b101, 2'b11, 1'b1);
    tick();
    chk("ds_gate.c1", NOCS_O);
    DS_n = 1'b0;
    tick();
    chk("ds_gate.c2", DUA_O);
    release_bus();
    tick();
    chk("wait_abort", IDLE_O);

    start(3'b101, 2'b10, 1'b0);
    tick();
    tick();
    chk("rstw.c2", ROM_O);
    #2 RST = 1'b1;
    #1;
    chk("rst_async", IDLE_O);
    release_bus();
    tick();
    chk("rst_hold", IDLE_O);
    RST = 1'b0;
    tick();

    start(3'b101, 2'b00, 1'b0);
    tick();
    chk("abort.c1", ROM_O);
    release_bus();
    tick();
    chk("abort.c2", IDLE_O);
    tick();
    chk("abort.c3", IDLE_O);

    rd("reboot1", 3'b101, 2'b00, 2, ROM_O, ROMA_O);
    rd("reboot2", 3'b101, 2'b00, 2, ROM_O, ROMA_O);
    rd("reboot_sram", 3'b101, 2'b00, 0, SRAM_O, SRAMA_O);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
